clk_enable_gen: RTL and testbench
=================================

Name: clk_enable_gen

Overview:
- Parametrised successor to the fixed PLL wrapper.
- Derives NUM_CHANNELS independent, runtime-programmable clock-enable streams and approximately 50%-duty divided clocks from one fabric clock.
- Uses per-channel phase accumulators (fractional division).
- Provides a locked indication that is deasserted during reset and reconfiguration.
- Sits downstream of the PLL output; feeds CPU, ACIA baud and video timing enables.

Parameters:
- NUM_CHANNELS, 2, number of independent output channels (1..16).
- ACC_WIDTH, 32, phase accumulator and increment width in bits (4..32).
- INC_DEFAULT, 35791394, reset increment for every channel. This is 1.0 MHz enable at 120 MHz: round(2^32/120).
- LOCK_CYCLES, 16, cycles of stable configuration before locked asserts (1..65535).

Ports:
- refclk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_wr  in  1  single-cycle write strobe for one channel's increment.
- cfg_chan  in  CHAN_W  target channel; CHAN_W = max(1, clog2(NUM_CHANNELS)).
- cfg_inc  in  ACC_WIDTH  new increment value.
- cfg_sync  in  1  single-cycle strobe; clears all accumulators simultaneously.
- ce_out  out  NUM_CHANNELS  one-cycle clock-enable pulse per channel.
- outclk  out  NUM_CHANNELS  divided clock per channel: registered accumulator MSB.
- locked  out  1  configuration stable and outputs valid.
- cfg_err  out  1  one-cycle pulse when cfg_wr targets an invalid channel.

Behaviour:
- Reset (async assert, release synchronous to refclk), per channel:
  - inc[i]=INC_DEFAULT, acc[i]=0.
  - ce_out=0, outclk=0, locked=0, cfg_err=0, lock counter=0.
- Per channel, every edge when not being cleared:
  - {carry, acc[i]} <= acc[i] + inc[i], computed in ACC_WIDTH+1 bits; wrap modulo 2^ACC_WIDTH.
  - ce_out[i] <= carry. It is registered and high exactly one cycle per wrap.
  - outclk[i] <= MSB of the new acc[i] value.
- Average ce rate = f_refclk * inc / 2^ACC_WIDTH. Jitter is at most 1 refclk period for non-power-of-2 ratios.
- inc[i]=0: channel frozen, ce_out[i]=0, outclk[i] holds the MSB of the frozen accumulator.
- Max inc = 2^ACC_WIDTH-1: ce_out high on every cycle except one per 2^ACC_WIDTH.
- cfg_wr with cfg_chan < NUM_CHANNELS:
  - Next edge: inc[chan]=cfg_inc, acc[chan]=0, ce_out[chan]=0, outclk[chan]=0.
  - Other channels are undisturbed.
- cfg_wr with cfg_chan >= NUM_CHANNELS:
  - Write ignored, no state change.
  - cfg_err=1 on the next cycle only.
  - Lock counter unaffected.
- cfg_sync:
  - Next edge: all acc=0, all ce_out=0, all outclk=0.
  - All increments retained.
- cfg_wr and cfg_sync in the same cycle: both take effect on that edge (increment written, all accumulators cleared).
- Lock state machine, two states, UNLOCKED and LOCKED:
  - UNLOCKED: counter increments each cycle. When counter == LOCK_CYCLES-1, go to LOCKED with locked=1 on that edge.
  - Any valid cfg_wr or any cfg_sync in either state: counter=0, locked=0 next edge, state UNLOCKED. A valid strobe arriving during the count restarts it.
  - locked first rises LOCK_CYCLES edges after the first edge following reset release, or after the last strobe.
  - Invalid cfg_wr does not affect lock.
- Outputs are driven and run during UNLOCKED. locked is advisory; consumers gate on it.
- Reset mid-operation: all state returns to reset values immediately, regardless of pending strobes.
- Counter width = clog2(LOCK_CYCLES+1). It saturates in LOCKED and never wraps.

Test Plan:
- ACC_WIDTH=8, NUM_CHANNELS=2, LOCK_CYCLES=4.
  - Stimulus: release reset, write inc=64 to ch0 and inc=96 to ch1.
  - Required: ch0 ce_out pulses every 4 cycles exactly. ch1 pulses 3 in 8 cycles (gaps 3,3,2 repeating). ch0 outclk is 2 high / 2 low.
- Lock timing:
  - Stimulus: release reset, no strobes.
  - Required: locked=0 for 3 edges, 1 from the 4th. A cfg_sync at cycle 10 gives locked=0 at cycle 11 and 1 again at cycle 15.
- Invalid channel (NUM_CHANNELS=3, CHAN_W=2):
  - Stimulus: cfg_wr with cfg_chan=3, inc=5.
  - Required: cfg_err high one cycle; increments unchanged; locked stays 1; ce streams unperturbed.
- Zero and max increment:
  - Stimulus: inc=0 on ch0, then inc=255 on ch0.
  - Required with inc=0: ce_out[0]=0 for 300 cycles, outclk[0] constant 0.
  - Required with inc=255: ce_out[0] high 255 of every 256 cycles.
- Simultaneous strobes:
  - Stimulus: cfg_wr (ch1, inc=32) and cfg_sync in the same cycle, ch0 inc=64.
  - Required: both accumulators are 0 next cycle; first ch0 ce 4 cycles later, first ch1 ce 8 cycles later; locked drops for 4 cycles.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously between edges while ce_out=1 and locked=1.
  - Required: ce_out, outclk and locked are 0 immediately. After release, increments equal INC_DEFAULT.

Source files
------------

// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator driven by per-channel phase accumulators.
// Each channel emits an enable pulse on accumulator wrap and a divided clock taken from the accumulator MSB.
module clk_enable_gen #(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned ACC_WIDTH    = 32,
    parameter int unsigned INC_DEFAULT  = 35791394,
    parameter int unsigned LOCK_CYCLES  = 16,
    localparam int unsigned CHAN_W      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    cfg_wr,
    input  logic [CHAN_W-1:0]       cfg_chan,
    input  logic [ACC_WIDTH-1:0]    cfg_inc,
    input  logic                    cfg_sync,
    output logic [NUM_CHANNELS-1:0] ce_out,
    output logic [NUM_CHANNELS-1:0] outclk,
    output logic                    locked,
    output logic                    cfg_err
);

    localparam int unsigned          CNT_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [ACC_WIDTH-1:0] INC_RST  = ACC_WIDTH'(INC_DEFAULT);

    typedef enum logic {S_UNLOCKED, S_LOCKED} lock_state_t;

    lock_state_t            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]   acc_q [NUM_CHANNELS];
    logic [ACC_WIDTH-1:0]   inc_q [NUM_CHANNELS];
    logic [ACC_WIDTH:0]     sum   [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] wr_sel;
    logic                   valid_wr;
    logic                   strobe;

    // Widened compare so a non-power-of-two channel count rejects the unused codes.
    assign valid_wr = cfg_wr && ({1'b0, cfg_chan} < (CHAN_W + 1)'(NUM_CHANNELS));
    assign strobe   = valid_wr || cfg_sync;
    assign locked   = (state_q == S_LOCKED);

    always_comb begin
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            wr_sel[i] = valid_wr && (cfg_chan == CHAN_W'(i));
            sum[i]    = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            ce_out  <= '0;
            outclk  <= '0;
            cfg_err <= 1'b0;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                acc_q[i] <= '0;
                inc_q[i] <= INC_RST;
            end
        end else begin
            cfg_err <= cfg_wr && !valid_wr;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                if (cfg_sync || wr_sel[i]) begin
                    acc_q[i]  <= '0;
                    ce_out[i] <= 1'b0;
                    outclk[i] <= 1'b0;
                end else begin
                    acc_q[i]  <= sum[i][ACC_WIDTH-1:0];
                    ce_out[i] <= sum[i][ACC_WIDTH];
                    outclk[i] <= sum[i][ACC_WIDTH-1];
                end
                if (wr_sel[i]) begin
                    inc_q[i] <= cfg_inc;
                end
            end
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q <= S_UNLOCKED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter holds its final value while locked, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (strobe) begin
            state_d = S_UNLOCKED;
            cnt_d   = '0;
        end else if (state_q == S_UNLOCKED) begin
            if (cnt_q == CNT_LAST) begin
                state_d = S_LOCKED;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: a 2-channel and a 3-channel instance, 8-bit accumulators, lock after 4 cycles.
module tb_clk_enable_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    logic       a_wr, a_sync, a_chan;
    logic [7:0] a_inc;
    logic [1:0] a_ce, a_oc;
    logic       a_lk, a_err;

    logic       b_wr, b_sync;
    logic [1:0] b_chan;
    logic [7:0] b_inc;
    logic [2:0] b_ce, b_oc;
    logic       b_lk, b_err;

    clk_enable_gen #(.NUM_CHANNELS(2), .ACC_WIDTH(8), .INC_DEFAULT(40), .LOCK_CYCLES(4)) dut_a (
        .refclk(clk), .rst(rst), .cfg_wr(a_wr), .cfg_chan(a_chan), .cfg_inc(a_inc),
        .cfg_sync(a_sync), .ce_out(a_ce), .outclk(a_oc), .locked(a_lk), .cfg_err(a_err)
    );

    clk_enable_gen #(.NUM_CHANNELS(3), .ACC_WIDTH(8), .INC_DEFAULT(40), .LOCK_CYCLES(4)) dut_b (
        .refclk(clk), .rst(rst), .cfg_wr(b_wr), .cfg_chan(b_chan), .cfg_inc(b_inc),
        .cfg_sync(b_sync), .ce_out(b_ce), .outclk(b_oc), .locked(b_lk), .cfg_err(b_err)
    );

    typedef struct {
        logic       wr;
        logic [1:0] chan;
        logic [7:0] inc;
        logic       sync;
        logic [2:0] ce;
        logic [2:0] oc;
        logic       lk;
        logic       err;
    } vec_t;

    vec_t ta [27];
    vec_t tv [11];

    int checks = 0;
    int fails  = 0;

    function automatic vec_t v(input logic wr, input logic [1:0] chan, input logic [7:0] inc,
                               input logic sync, input logic [2:0] ce, input logic [2:0] oc,
                               input logic lk, input logic err);
        vec_t r;
        r.wr = wr; r.chan = chan; r.inc = inc; r.sync = sync;
        r.ce = ce; r.oc = oc; r.lk = lk; r.err = err;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        a_wr = 0; a_sync = 0; a_chan = 0; a_inc = 0;
        b_wr = 0; b_sync = 0; b_chan = 0; b_inc = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.a_ce", a_ce, 0);
        check("rst.a_oc", a_oc, 0);
        check("rst.a_lk", a_lk, 0);
        check("rst.a_err", a_err, 0);
        check("rst.b_ce", b_ce, 0);
        check("rst.b_lk", b_lk, 0);
        rst = 1'b0;
    endtask

    task automatic step_a(input vec_t r, input int idx);
        a_wr = r.wr; a_chan = r.chan[0]; a_inc = r.inc; a_sync = r.sync;
        @(posedge clk); #1;
        a_wr = 0; a_sync = 0;
        check($sformatf("A[%0d].ce", idx), a_ce, r.ce[1:0]);
        check($sformatf("A[%0d].outclk", idx), a_oc, r.oc[1:0]);
        check($sformatf("A[%0d].locked", idx), a_lk, r.lk);
        check($sformatf("A[%0d].cfg_err", idx), a_err, r.err);
    endtask

    task automatic step_b(input vec_t r, input int idx);
        b_wr = r.wr; b_chan = r.chan; b_inc = r.inc; b_sync = r.sync;
        @(posedge clk); #1;
        b_wr = 0; b_sync = 0;
        check($sformatf("B[%0d].ce", idx), b_ce, r.ce);
        check($sformatf("B[%0d].outclk", idx), b_oc, r.oc);
        check($sformatf("B[%0d].locked", idx), b_lk, r.lk);
        check($sformatf("B[%0d].cfg_err", idx), b_err, r.err);
    endtask

    task automatic write_a(input logic chan, input logic [7:0] inc);
        a_wr = 1'b1; a_chan = chan; a_inc = inc;
        @(posedge clk); #1;
        a_wr = 1'b0;
    endtask

    initial begin
        int cnt;
        int waited;

        // 3-channel instance: default inc 40, invalid write to ch3, then valid write to ch2.
        //          wr chan inc    sync ce      oc      lk err
        tv[0]  = v(0, 0, 8'd0,   0, 3'b000, 3'b000, 0, 0);
        tv[1]  = v(0, 0, 8'd0,   0, 3'b000, 3'b000, 0, 0);
        tv[2]  = v(0, 0, 8'd0,   0, 3'b000, 3'b000, 0, 0);
        tv[3]  = v(0, 0, 8'd0,   0, 3'b000, 3'b111, 1, 0);
        tv[4]  = v(1, 3, 8'd5,   0, 3'b000, 3'b111, 1, 1);
        tv[5]  = v(0, 0, 8'd0,   0, 3'b000, 3'b111, 1, 0);
        tv[6]  = v(0, 0, 8'd0,   0, 3'b111, 3'b000, 1, 0);
        tv[7]  = v(0, 0, 8'd0,   0, 3'b000, 3'b000, 1, 0);
        tv[8]  = v(1, 2, 8'd128, 0, 3'b000, 3'b000, 0, 0);
        tv[9]  = v(0, 0, 8'd0,   0, 3'b000, 3'b111, 0, 0);
        tv[10] = v(0, 0, 8'd0,   0, 3'b100, 3'b011, 0, 0);

        // 2-channel instance: ch0=64, ch1=96, then a sync, then simultaneous write(ch1=32)+sync.
        ta[0]  = v(1, 0, 8'd64,  0, 3'b000, 3'b000, 0, 0);
        ta[1]  = v(1, 1, 8'd96,  0, 3'b000, 3'b000, 0, 0);
        ta[2]  = v(0, 0, 8'd0,   0, 3'b000, 3'b001, 0, 0);
        ta[3]  = v(0, 0, 8'd0,   0, 3'b000, 3'b011, 0, 0);
        ta[4]  = v(0, 0, 8'd0,   0, 3'b011, 3'b000, 0, 0);
        ta[5]  = v(0, 0, 8'd0,   0, 3'b000, 3'b010, 1, 0);
        ta[6]  = v(0, 0, 8'd0,   0, 3'b000, 3'b011, 1, 0);
        ta[7]  = v(0, 0, 8'd0,   0, 3'b010, 3'b001, 1, 0);
        ta[8]  = v(0, 0, 8'd0,   0, 3'b001, 3'b010, 1, 0);
        ta[9]  = v(0, 0, 8'd0,   0, 3'b010, 3'b000, 1, 0);
        ta[10] = v(0, 0, 8'd0,   0, 3'b000, 3'b001, 1, 0);
        ta[11] = v(0, 0, 8'd0,   0, 3'b000, 3'b011, 1, 0);
        ta[12] = v(0, 0, 8'd0,   0, 3'b011, 3'b000, 1, 0);
        ta[13] = v(0, 0, 8'd0,   1, 3'b000, 3'b000, 0, 0);
        ta[14] = v(0, 0, 8'd0,   0, 3'b000, 3'b000, 0, 0);
        ta[15] = v(0, 0, 8'd0,   0, 3'b000, 3'b011, 0, 0);
        ta[16] = v(0, 0, 8'd0,   0, 3'b010, 3'b001, 0, 0);
        ta[17] = v(0, 0, 8'd0,   0, 3'b001, 3'b010, 1, 0);
        ta[18] = v(1, 1, 8'd32,  1, 3'b000, 3'b000, 0, 0);
        ta[19] = v(0, 0, 8'd0,   0, 3'b000, 3'b000, 0, 0);
        ta[20] = v(0, 0, 8'd0,   0, 3'b000, 3'b001, 0, 0);
        ta[21] = v(0, 0, 8'd0,   0, 3'b000, 3'b001, 0, 0);
        ta[22] = v(0, 0, 8'd0,   0, 3'b001, 3'b010, 1, 0);
        ta[23] = v(0, 0, 8'd0,   0, 3'b000, 3'b010, 1, 0);
        ta[24] = v(0, 0, 8'd0,   0, 3'b000, 3'b011, 1, 0);
        ta[25] = v(0, 0, 8'd0,   0, 3'b000, 3'b011, 1, 0);
        ta[26] = v(0, 0, 8'd0,   0, 3'b011, 3'b000, 1, 0);

        rst = 1'b1;
        a_wr = 0; a_sync = 0; a_chan = 0; a_inc = 0;
        b_wr = 0; b_sync = 0; b_chan = 0; b_inc = 0;

        do_reset();
        for (int i = 0; i < 11; i++) step_b(tv[i], i);

        do_reset();
        for (int i = 0; i < 27; i++) step_a(ta[i], i);

        // Zero increment freezes ch0; ch1 (inc 32) keeps an exact 1-in-8 rate.
        write_a(1'b0, 8'd0);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            check("zero.ce0", a_ce[0], 1'b0);
            check("zero.outclk0", a_oc[0], 1'b0);
            if (i < 256 && a_ce[1]) cnt++;
        end
        check("zero.ch1_pulses", cnt, 32);

        // Maximum increment: 255 enables in every 256 cycles.
        write_a(1'b0, 8'd255);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            if (a_ce[0]) cnt++;
        end
        check("max.ce0_count", cnt, 255);

        // Asynchronous reset between edges while ce_out and locked are high.
        waited = 0;
        while (!(a_ce[0] && a_lk) && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("midrst.precondition", (a_ce[0] && a_lk), 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst.ce", a_ce, 0);
        check("midrst.outclk", a_oc, 0);
        check("midrst.locked", a_lk, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        // Default increment 40: acc 40,80,120,160,200,240,24 -> MSB high on edges 4..6, wrap on edge 7.
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            check($sformatf("post_rst[%0d].ce", e), a_ce, (e == 7) ? 2'b11 : 2'b00);
            check($sformatf("post_rst[%0d].outclk", e), a_oc, (e >= 4 && e <= 6) ? 2'b11 : 2'b00);
            check($sformatf("post_rst[%0d].locked", e), a_lk, (e >= 4) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
